// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, functs,
// FSM states, instruction classes and the datapath mux select values.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_SLL   = 6'b000000;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0,
    S_DCD   = 4'd1,
    S_EXE   = 4'd2,
    S_ALUWB = 4'd3,
    S_MA    = 4'd4,
    S_MR    = 4'd5,
    S_MWB   = 4'd6,
    S_MW    = 4'd7,
    S_BR    = 4'd8,
    S_JMP   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_NOP, C_BAD
  } iclass_t;

  localparam logic [1:0] EOP_SIGN = 2'b00;
  localparam logic [1:0] EOP_ZERO = 2'b01;
  localparam logic [1:0] EOP_HI   = 2'b10;
  localparam logic [1:0] EOP_SHL2 = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b10;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;
  localparam logic [1:0] WD_PC4   = 2'b10;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and ALU flag in, enables and
// mux selects out, plus retire count, illegal flag and the current state.
interface mips_mc_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        PCWr;
  logic        IRWr;
  logic        RegWr;
  logic        MemWr;
  logic [1:0]  EOp;
  logic        ALUSrc;
  logic [1:0]  ALUOp;
  logic [1:0]  RegDst;
  logic [1:0]  WDSel;
  logic [1:0]  NPCOp;
  logic [31:0] instr_cnt;
  logic        illegal;
  logic [3:0]  state;

  modport master (
    input  opcode, funct, zero,
    output PCWr, IRWr, RegWr, MemWr, EOp, ALUSrc, ALUOp, RegDst, WDSel, NPCOp,
    output instr_cnt, illegal, state
  );

  modport slave (
    output opcode, funct, zero,
    input  PCWr, IRWr, RegWr, MemWr, EOp, ALUSrc, ALUOp, RegDst, WDSel, NPCOp,
    input  instr_cnt, illegal, state
  );
endinterface

// File: rtl/mips_mc_decode.sv
// Combinational opcode/funct classifier; anything unsupported maps to C_BAD.
module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls
);

  always_comb begin
    cls = C_BAD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU: cls = C_ALU_R;
          FN_JR:            cls = C_JR;
          FN_SLL:           cls = C_NOP;
          default:          cls = C_BAD;
        endcase
      end
      OP_ORI:  cls = C_ORI;
      OP_LUI:  cls = C_LUI;
      OP_LW:   cls = C_LW;
      OP_SW:   cls = C_SW;
      OP_BEQ:  cls = C_BEQ;
      OP_J:    cls = C_J;
      OP_JAL:  cls = C_JAL;
      default: cls = C_BAD;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main controller: FSM, retire counter and sticky illegal flag.
//   state | meaning
//   FETCH | PC <= PC+4, IR <= mem[PC]
//   DCD   | classify opcode/funct
//   EXE   | ALU op for R-type/ori/lui
//   ALUWB | write ALU result
//   MA    | address calc for lw/sw
//   MR    | memory read
//   MWB   | write loaded data
//   MW    | memory write
//   BR    | beq compare and conditional PC update
//   JMP   | j/jal/jr PC update (jal links $31)
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  mips_mc_ctrl_if.master  bus
);

  state_t      state_q, state_d;
  iclass_t     cls;
  logic [31:0] cnt_q;
  logic        ill_q;
  logic        retire, set_ill;
  logic        pc_we, ir_we, reg_we, mem_we;
  logic [1:0]  eop, aluop, regdst, wdsel, npcop;
  logic        alusrc;

  mips_mc_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      if (retire)  cnt_q <= cnt_q + 32'd1;
      if (set_ill) ill_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    eop     = EOP_SIGN;
    alusrc  = 1'b0;
    aluop   = ALU_ADD;
    regdst  = RD_RT;
    wdsel   = WD_ALU;
    npcop   = NPC_SEQ;
    retire  = 1'b0;
    set_ill = 1'b0;
    case (state_q)
      S_FETCH: begin
        pc_we   = 1'b1;
        ir_we   = 1'b1;
        state_d = S_DCD;
      end
      S_DCD: begin
        case (cls)
          C_ALU_R, C_NOP, C_ORI, C_LUI: state_d = S_EXE;
          C_LW, C_SW:                   state_d = S_MA;
          C_BEQ:                        state_d = S_BR;
          C_J, C_JAL, C_JR:             state_d = S_JMP;
          default: begin
            state_d = S_FETCH;
            set_ill = 1'b1;
          end
        endcase
      end
      S_EXE: begin
        if (cls == C_ALU_R && bus.funct == FN_SUBU) aluop = ALU_SUB;
        if (cls == C_ORI) begin
          aluop  = ALU_OR;
          alusrc = 1'b1;
          eop    = EOP_ZERO;
        end
        if (cls == C_LUI) begin
          aluop  = ALU_OR;
          alusrc = 1'b1;
          eop    = EOP_HI;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = (cls != C_NOP);
        regdst  = (cls == C_ALU_R || cls == C_NOP) ? RD_RD : RD_RT;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MA: begin
        alusrc  = 1'b1;
        state_d = (cls == C_LW) ? S_MR : S_MW;
      end
      S_MR: state_d = S_MWB;
      S_MWB: begin
        reg_we  = 1'b1;
        wdsel   = WD_MEM;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MW: begin
        mem_we  = 1'b1;
        alusrc  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BR: begin
        aluop   = ALU_SUB;
        eop     = EOP_SHL2;
        npcop   = NPC_BR;
        pc_we   = bus.zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JMP: begin
        pc_we = 1'b1;
        npcop = (cls == C_JR) ? NPC_RS : NPC_JMP;
        if (cls == C_JAL) begin
          reg_we = 1'b1;
          regdst = RD_RA;
          wdsel  = WD_PC4;
        end
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are qualified by en and reset so stalls and reset never write.
  assign bus.PCWr      = pc_we  & en & rst_n;
  assign bus.IRWr      = ir_we  & en & rst_n;
  assign bus.RegWr     = reg_we & en & rst_n;
  assign bus.MemWr     = mem_we & en & rst_n;
  assign bus.EOp       = eop;
  assign bus.ALUSrc    = alusrc;
  assign bus.ALUOp     = aluop;
  assign bus.RegDst    = regdst;
  assign bus.WDSel     = wdsel;
  assign bus.NPCOp     = npcop;
  assign bus.instr_cnt = cnt_q;
  assign bus.illegal   = ill_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: directed instructions push expected
// per-cycle output vectors; a monitor pops and compares each cycle.
`timescale 1ns/1ps
module tb_mips_mc_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  mips_mc_ctrl_if bus();

  mips_mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [51:0] exp_q[$];
  string       tag_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic        exp_ill = 1'b0;

  function automatic logic [51:0] v(input logic [3:0] st, input logic pc, input logic ir,
                                    input logic rw, input logic mw, input logic [1:0] eop,
                                    input logic as, input logic [1:0] aop, input logic [1:0] rd,
                                    input logic [1:0] wd, input logic [1:0] np);
    return {st, pc, ir, rw, mw, eop, as, aop, rd, wd, np, exp_ill, exp_cnt};
  endfunction

  task automatic put(input string tag, input logic [51:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  task automatic fd(input logic [5:0] op, input logic [5:0] fn, input logic z);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    put("FETCH", v(4'd0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    put("DCD",   v(4'd1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
  endtask

  // Monitor: compare the DUT outputs against the oldest expected vector.
  always @(negedge clk) begin
    logic [51:0] e, a;
    string t;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {bus.state, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.EOp, bus.ALUSrc,
           bus.ALUOp, bus.RegDst, bus.WDSel, bus.NPCOp, bus.illegal, bus.instr_cnt};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", t, a, e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    bus.opcode = 6'd0;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
    @(negedge clk);
    put("reset", v(4'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    rst_n = 1'b1;
    en = 1'b1;

    // ori
    fd(6'b001101, 6'd0, 0);
    put("ori EXE",   v(4'd2, 0, 0, 0, 0, 2'b01, 1, 2'b10, 2'b00, 2'b00, 2'b00));
    put("ori ALUWB", v(4'd3, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    exp_cnt++;
    // addu
    fd(6'b000000, 6'b100001, 0);
    put("addu EXE",   v(4'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    put("addu ALUWB", v(4'd3, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 2'b00));
    exp_cnt++;
    // subu
    fd(6'b000000, 6'b100011, 0);
    put("subu EXE",   v(4'd2, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 2'b00));
    put("subu ALUWB", v(4'd3, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 2'b00));
    exp_cnt++;
    // sll as nop: no register write
    fd(6'b000000, 6'b000000, 0);
    put("sll EXE",   v(4'd2, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    put("sll ALUWB", v(4'd3, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 2'b00));
    exp_cnt++;
    // lw
    fd(6'b100011, 6'd0, 0);
    put("lw MA",  v(4'd4, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00));
    put("lw MR",  v(4'd5, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    put("lw MWB", v(4'd6, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b01, 2'b00));
    exp_cnt++;
    // sw with a 3-cycle stall in MW
    fd(6'b101011, 6'd0, 0);
    put("sw MA", v(4'd4, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00));
    en = 1'b0;
    for (int i = 0; i < 3; i++)
      put("sw MW stall", v(4'd7, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00));
    en = 1'b1;
    put("sw MW", v(4'd7, 0, 0, 0, 1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 2'b00));
    exp_cnt++;
    // beq taken / not taken
    fd(6'b000100, 6'd0, 1);
    put("beq z=1 BR", v(4'd8, 1, 0, 0, 0, 2'b11, 0, 2'b01, 2'b00, 2'b00, 2'b01));
    exp_cnt++;
    fd(6'b000100, 6'd0, 0);
    put("beq z=0 BR", v(4'd8, 0, 0, 0, 0, 2'b11, 0, 2'b01, 2'b00, 2'b00, 2'b01));
    exp_cnt++;
    // jal, j, jr
    fd(6'b000011, 6'd0, 0);
    put("jal JMP", v(4'd9, 1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b10, 2'b10, 2'b10));
    exp_cnt++;
    fd(6'b000010, 6'd0, 0);
    put("j JMP", v(4'd9, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b10));
    exp_cnt++;
    fd(6'b000000, 6'b001000, 0);
    put("jr JMP", v(4'd9, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b11));
    exp_cnt++;
    // illegal opcode: back to FETCH, flag set, count unchanged
    fd(6'b111111, 6'd0, 0);
    exp_ill = 1'b1;
    // lui after illegal; flag stays set
    fd(6'b001111, 6'd0, 0);
    put("lui EXE",   v(4'd2, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00));
    put("lui ALUWB", v(4'd3, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    exp_cnt++;
    // reset in the middle of EXE
    fd(6'b001101, 6'd0, 0);
    rst_n = 1'b0;
    exp_cnt = 32'd0;
    exp_ill = 1'b0;
    put("reset mid EXE", v(4'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    rst_n = 1'b1;
    fd(6'b001101, 6'd0, 0);
    put("ori2 EXE",   v(4'd2, 0, 0, 0, 0, 2'b01, 1, 2'b10, 2'b00, 2'b00, 2'b00));
    put("ori2 ALUWB", v(4'd3, 0, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));
    exp_cnt++;
    // counter wrap from all-ones
    force dut.cnt_q = 32'hFFFF_FFFF;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    fd(6'b000010, 6'd0, 0);
    put("wrap JMP", v(4'd9, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b10));
    exp_cnt++;
    put("wrap FETCH", v(4'd0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
